// File: rtl/float_pack.sv
// Iterative signed 32-bit integer to IEEE-754 single converter (normalise loop, then round/pack).
// Define FLOAT_PACK_ROUND_EN for round-to-nearest-even; otherwise the mantissa is truncated.
module float_pack #(
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  output logic [31:0] out,
  output logic        busy,
  output logic        done
);

  localparam int unsigned DW = 32;
  localparam int unsigned EW = 8;
  localparam int unsigned MW = 23;
  localparam logic [EW-1:0] EXP_TOP = 8'd158;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] mag_q, mag_d;
  logic [EW-1:0] exp_q, exp_d;
  logic          sign_q, sign_d;
  logic          zero_q, zero_d;
  logic [DW-1:0] out_d;
  logic          busy_d, done_d;

  logic [DW-1:0] abs_c;
  logic [MW-1:0] mant_rnd_c;
  logic [EW-1:0] exp_rnd_c;

  // Magnitude of the operand; 0x80000000 maps onto itself as an unsigned value.
  always_comb begin
    abs_c = a;
    if (a[DW-1]) begin
      abs_c = ~a + 32'd1;
    end
  end

`ifdef FLOAT_PACK_ROUND_EN
  logic          inc_c;
  logic [MW:0]   mant_sum_c;

  // Round to nearest even; a carry out of the mantissa bumps the exponent.
  always_comb begin
    inc_c      = mag_q[7] & ((|mag_q[6:0]) | mag_q[8]);
    mant_sum_c = {1'b0, mag_q[DW-2:DW-1-MW]} + 24'(inc_c);
    mant_rnd_c = mant_sum_c[MW-1:0];
    exp_rnd_c  = exp_q + 8'(mant_sum_c[MW]);
  end
`else
  // Truncation: bits below the mantissa are simply dropped.
  always_comb begin
    mant_rnd_c = mag_q[DW-2:DW-1-MW];
    exp_rnd_c  = exp_q;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mag_q   <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      zero_q  <= 1'b0;
      out     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
      zero_q  <= zero_d;
      out     <= out_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Next-state and next-register values.
  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    zero_d  = zero_q;
    out_d   = out;
    busy_d  = busy;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          sign_d  = a[DW-1];
          mag_d   = abs_c;
          exp_d   = EXP_TOP;
          zero_d  = (abs_c == '0);
          busy_d  = 1'b1;
          state_d = (abs_c == '0) ? ROUND : NORM;
        end
      end
      NORM: begin
        if (mag_q[DW-1]) begin
          state_d = ROUND;
        end else if (mag_q[DW-1 -: SHIFT_STEP] == '0) begin
          mag_d = mag_q << SHIFT_STEP;
          exp_d = exp_q - 8'(SHIFT_STEP);
        end else begin
          mag_d = mag_q << 1;
          exp_d = exp_q - 8'd1;
        end
      end
      ROUND: begin
        out_d   = zero_q ? '0 : {sign_q, exp_rnd_c, mant_rnd_c};
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
